// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit CPU boot path: instruction width,
// default memory geometry and the instruction loader state encoding.
package cpu_pkg;

   localparam int INSTR_W    = 16;
   localparam int ADDR_W_DEF = 16;
   localparam int DEPTH_DEF  = 256;

   typedef enum logic [2:0] {
      HDR_HI = 3'd0,
      HDR_LO = 3'd1,
      DAT_HI = 3'd2,
      DAT_LO = 3'd3,
      DONE   = 3'd4
   } loader_state_t;

endpackage

// File: rtl/instr_mem_loader_if.sv
// Byte stream handshake plus instruction memory write port of the loader.
// The slave side is the loader itself; the master side feeds bytes and observes writes.
interface instr_mem_loader_if #(
   parameter int ADDR_W = cpu_pkg::ADDR_W_DEF
);

   logic [7:0]                  in_data;
   logic                        in_valid;
   logic                        in_ready;
   logic                        mem_we;
   logic [ADDR_W-1:0]           mem_addr;
   logic [cpu_pkg::INSTR_W-1:0] mem_wdata;

   modport master (
      output in_data, in_valid,
      input  in_ready, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      input  in_data, in_valid,
      output in_ready, mem_we, mem_addr, mem_wdata
   );

endinterface

// File: rtl/instr_mem_loader.sv
// Boot-time instruction memory writer: turns a counted big-endian byte stream
// into word writes from BASE_ADDR and keeps the CPU held until the image is in.
module instr_mem_loader
   import cpu_pkg::*;
#(
   parameter int ADDR_W    = ADDR_W_DEF,
   parameter int DEPTH     = DEPTH_DEF,
   parameter int BASE_ADDR = 0
) (
   input  logic                clk,
   input  logic                rst_n,
   instr_mem_loader_if.slave   bus,
   input  logic                reload,
   output logic                cpu_hold,
   output logic                load_done,
   output logic                overflow
);

   loader_state_t        state_q;
   loader_state_t        state_next;
   logic [15:0]          count_q;
   logic [7:0]           hi_q;
   logic [ADDR_W:0]      idx_q;
   logic                 mem_we_q;
   logic [ADDR_W-1:0]    mem_addr_q;
   logic [INSTR_W-1:0]   mem_wdata_q;
   logic                 cpu_hold_q;
   logic                 load_done_q;
   logic                 overflow_q;

   logic                 accept;
   logic [15:0]          header_word;
   logic [31:0]          idx_inc;
   logic                 last_word;
   logic                 in_range;

   // Compare counters in 32 bits so any ADDR_W works against the 16-bit count
   assign accept      = bus.in_valid && bus.in_ready;
   assign header_word = {count_q[15:8], bus.in_data};
   assign idx_inc     = 32'(idx_q) + 32'd1;
   assign last_word   = (idx_inc == 32'(count_q));
   assign in_range    = (32'(idx_q) < 32'(DEPTH));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= HDR_HI;
      else        state_q <= state_next;
   end

   always_comb begin
      state_next = state_q;
      unique case (state_q)
         HDR_HI: if (accept) state_next = HDR_LO;
         HDR_LO: if (accept) state_next = (header_word == 16'd0) ? DONE : DAT_HI;
         DAT_HI: if (accept) state_next = DAT_LO;
         DAT_LO: if (accept) state_next = last_word ? DONE : DAT_HI;
         DONE:   if (reload) state_next = HDR_HI;
         default: state_next = HDR_HI;
      endcase
   end

   always_comb begin
      bus.in_ready = (state_q != DONE);
   end

   // Word assembly, write issue, and the registered status flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q     <= '0;
         hi_q        <= '0;
         idx_q       <= '0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         cpu_hold_q  <= 1'b1;
         load_done_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         mem_we_q    <= 1'b0;
         cpu_hold_q  <= (state_q != DONE) || reload;
         load_done_q <= accept && (((state_q == HDR_LO) && (header_word == 16'd0)) ||
                                   ((state_q == DAT_LO) && last_word));
         if ((state_q == DONE) && reload) begin
            overflow_q <= 1'b0;
            idx_q      <= '0;
            count_q    <= '0;
         end
         if (accept) begin
            unique case (state_q)
               HDR_HI: count_q[15:8] <= bus.in_data;
               HDR_LO: count_q[7:0]  <= bus.in_data;
               DAT_HI: hi_q          <= bus.in_data;
               DAT_LO: begin
                  idx_q <= idx_q + 1'b1;
                  if (in_range) begin
                     mem_we_q    <= 1'b1;
                     mem_addr_q  <= ADDR_W'(BASE_ADDR) + idx_q[ADDR_W-1:0];
                     mem_wdata_q <= {hi_q, bus.in_data};
                  end else begin
                     overflow_q  <= 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign cpu_hold      = cpu_hold_q;
   assign load_done     = load_done_q;
   assign overflow      = overflow_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader with DEPTH=4 so the overflow path is reachable;
// inputs change and outputs are sampled on the falling clock edge.
module tb_instr_mem_loader;

   logic clk;
   logic rst_n;
   logic reload;
   logic cpu_hold;
   logic load_done;
   logic overflow;

   int tests;
   int fails;
   int wrCount;
   int wrBase;

   instr_mem_loader_if #(.ADDR_W(16)) bus ();

   instr_mem_loader #(
      .ADDR_W   (16),
      .DEPTH    (4),
      .BASE_ADDR(0)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus),
      .reload   (reload),
      .cpu_hold (cpu_hold),
      .load_done(load_done),
      .overflow (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one cycle of inputs, advance to the next falling edge and tally writes
   task automatic applyStimulus(input logic v, input logic [7:0] d, input logic rl);
      bus.in_valid = v;
      bus.in_data  = d;
      reload       = rl;
      @(negedge clk);
      reload = 1'b0;
      if (bus.mem_we === 1'b1) wrCount++;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      tests        = 0;
      fails        = 0;
      wrCount      = 0;
      rst_n        = 1'b0;
      reload       = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      checkOutput("rst_in_ready",  32'(bus.in_ready),  32'd1);
      checkOutput("rst_cpu_hold",  32'(cpu_hold),      32'd1);
      checkOutput("rst_mem_we",    32'(bus.mem_we),    32'd0);
      checkOutput("rst_mem_addr",  32'(bus.mem_addr),  32'd0);
      checkOutput("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
      checkOutput("rst_load_done", 32'(load_done),     32'd0);
      checkOutput("rst_overflow",  32'(overflow),      32'd0);

      // Two-word image, back to back
      applyStimulus(1'b1, 8'h00, 1'b0);
      applyStimulus(1'b1, 8'h02, 1'b0);
      applyStimulus(1'b1, 8'h12, 1'b0);
      checkOutput("b2b_no_we_hi", 32'(bus.mem_we), 32'd0);
      applyStimulus(1'b1, 8'h34, 1'b0);
      checkOutput("b2b_we0",     32'(bus.mem_we),    32'd1);
      checkOutput("b2b_addr0",   32'(bus.mem_addr),  32'h0000);
      checkOutput("b2b_data0",   32'(bus.mem_wdata), 32'h1234);
      checkOutput("b2b_done0",   32'(load_done),     32'd0);
      applyStimulus(1'b1, 8'hAB, 1'b0);
      checkOutput("b2b_we_gap",  32'(bus.mem_we),    32'd0);
      applyStimulus(1'b1, 8'hCD, 1'b0);
      checkOutput("b2b_we1",     32'(bus.mem_we),    32'd1);
      checkOutput("b2b_addr1",   32'(bus.mem_addr),  32'h0001);
      checkOutput("b2b_data1",   32'(bus.mem_wdata), 32'hABCD);
      checkOutput("b2b_done1",   32'(load_done),     32'd1);
      checkOutput("b2b_hold_on", 32'(cpu_hold),      32'd1);
      checkOutput("b2b_ready0",  32'(bus.in_ready),  32'd0);
      applyStimulus(1'b1, 8'hEE, 1'b0);
      checkOutput("b2b_hold_off",   32'(cpu_hold),     32'd0);
      checkOutput("b2b_done_pulse", 32'(load_done),    32'd0);
      checkOutput("b2b_wr_count",   32'(wrCount),      32'd2);
      checkOutput("b2b_ignore_byte", 32'(bus.mem_we),  32'd0);

      // Empty image: header 00 00
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkOutput("n0_hold_back", 32'(cpu_hold),     32'd1);
      checkOutput("n0_ready",     32'(bus.in_ready), 32'd1);
      wrBase = wrCount;
      applyStimulus(1'b1, 8'h00, 1'b0);
      checkOutput("n0_done_early", 32'(load_done), 32'd0);
      applyStimulus(1'b1, 8'h00, 1'b0);
      checkOutput("n0_done",   32'(load_done),    32'd1);
      checkOutput("n0_ready0", 32'(bus.in_ready), 32'd0);
      applyStimulus(1'b0, 8'h00, 1'b0);
      checkOutput("n0_hold_off", 32'(cpu_hold),         32'd0);
      checkOutput("n0_no_write", 32'(wrCount - wrBase), 32'd0);

      // Six words into a four-word memory
      applyStimulus(1'b0, 8'h00, 1'b1);
      wrBase = wrCount;
      applyStimulus(1'b1, 8'h00, 1'b0);
      applyStimulus(1'b1, 8'h06, 1'b0);
      for (int i = 0; i < 6; i++) begin
         checkOutput($sformatf("ovf_ready_hi%0d", i), 32'(bus.in_ready), 32'd1);
         applyStimulus(1'b1, 8'h10 + 8'(i), 1'b0);
         checkOutput($sformatf("ovf_ready_lo%0d", i), 32'(bus.in_ready), 32'd1);
         applyStimulus(1'b1, 8'h20 + 8'(i), 1'b0);
         checkOutput($sformatf("ovf_we%0d", i),   32'(bus.mem_we), (i < 4) ? 32'd1 : 32'd0);
         checkOutput($sformatf("ovf_flag%0d", i), 32'(overflow),   (i < 4) ? 32'd0 : 32'd1);
         if (i < 4) begin
            checkOutput($sformatf("ovf_addr%0d", i), 32'(bus.mem_addr), 32'(i));
            checkOutput($sformatf("ovf_data%0d", i), 32'(bus.mem_wdata), 32'h1020 + 32'h0101 * 32'(i));
         end
      end
      checkOutput("ovf_done",   32'(load_done),        32'd1);
      checkOutput("ovf_writes", 32'(wrCount - wrBase), 32'd4);
      applyStimulus(1'b0, 8'h00, 1'b0);
      checkOutput("ovf_sticky", 32'(overflow), 32'd1);

      // One word with gaps in in_valid and a reload mid-load
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkOutput("gap_ovf_cleared", 32'(overflow), 32'd0);
      checkOutput("gap_hold_back",   32'(cpu_hold), 32'd1);
      wrBase = wrCount;
      applyStimulus(1'b1, 8'h00, 1'b0);
      applyStimulus(1'b0, 8'hFF, 1'b0);
      applyStimulus(1'b0, 8'hFF, 1'b1);
      applyStimulus(1'b1, 8'h01, 1'b0);
      applyStimulus(1'b0, 8'hFF, 1'b0);
      applyStimulus(1'b1, 8'h5A, 1'b1);
      checkOutput("gap_ready_mid", 32'(bus.in_ready),     32'd1);
      checkOutput("gap_no_write",  32'(wrCount - wrBase), 32'd0);
      applyStimulus(1'b0, 8'hFF, 1'b0);
      applyStimulus(1'b1, 8'hA5, 1'b0);
      checkOutput("gap_we",   32'(bus.mem_we),    32'd1);
      checkOutput("gap_addr", 32'(bus.mem_addr),  32'h0000);
      checkOutput("gap_data", 32'(bus.mem_wdata), 32'h5AA5);
      checkOutput("gap_done", 32'(load_done),     32'd1);
      applyStimulus(1'b0, 8'h00, 1'b0);
      checkOutput("gap_writes", 32'(wrCount - wrBase), 32'd1);

      // Asynchronous reset in the middle of a word
      applyStimulus(1'b0, 8'h00, 1'b1);
      applyStimulus(1'b1, 8'h00, 1'b0);
      applyStimulus(1'b1, 8'h01, 1'b0);
      applyStimulus(1'b1, 8'h77, 1'b0);
      bus.in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("arst_wdata",    32'(bus.mem_wdata), 32'd0);
      checkOutput("arst_addr",     32'(bus.mem_addr),  32'd0);
      checkOutput("arst_we",       32'(bus.mem_we),    32'd0);
      checkOutput("arst_hold",     32'(cpu_hold),      32'd1);
      checkOutput("arst_done",     32'(load_done),     32'd0);
      checkOutput("arst_overflow", 32'(overflow),      32'd0);
      checkOutput("arst_ready",    32'(bus.in_ready),  32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(1'b1, 8'h00, 1'b0);
      applyStimulus(1'b1, 8'h01, 1'b0);
      applyStimulus(1'b1, 8'h11, 1'b0);
      applyStimulus(1'b1, 8'h22, 1'b0);
      checkOutput("arst_we_after",   32'(bus.mem_we),    32'd1);
      checkOutput("arst_addr_after", 32'(bus.mem_addr),  32'h0000);
      checkOutput("arst_data_after", 32'(bus.mem_wdata), 32'h1122);
      checkOutput("arst_done_after", 32'(load_done),     32'd1);
      applyStimulus(1'b0, 8'h00, 1'b0);
      checkOutput("arst_hold_off", 32'(cpu_hold), 32'd0);

      // Reload from DONE and load one more word
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkOutput("rl_hold",  32'(cpu_hold),     32'd1);
      checkOutput("rl_ready", 32'(bus.in_ready), 32'd1);
      applyStimulus(1'b1, 8'h00, 1'b0);
      applyStimulus(1'b1, 8'h01, 1'b0);
      applyStimulus(1'b1, 8'hBE, 1'b0);
      applyStimulus(1'b1, 8'hEF, 1'b0);
      checkOutput("rl_we",   32'(bus.mem_we),    32'd1);
      checkOutput("rl_addr", 32'(bus.mem_addr),  32'h0000);
      checkOutput("rl_data", 32'(bus.mem_wdata), 32'hBEEF);
      checkOutput("rl_ovf",  32'(overflow),      32'd0);
      applyStimulus(1'b0, 8'h00, 1'b0);
      checkOutput("rl_hold_off", 32'(cpu_hold), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
